// File: rtl/freq_edge_pio_if.sv
// Avalon-MM slave bus bundle for the freq_edge_pio register block.
interface freq_edge_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/freq_edge_pio.sv
// Edge-capturing parallel input port: synchronised pins, per-channel edge modes,
// sticky capture with masked level IRQ, and one selectable edge counter.
module freq_edge_pio #(
    parameter int               WIDTH        = 8,
    parameter int               SYNC_STAGES  = 2,
    parameter int               CNT_W        = 16,
    parameter logic [WIDTH-1:0] IRQ_MASK_RST = '0
) (
    input  logic             clk,
    input  logic             reset,
    freq_edge_pio_if.slave   bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int EM_W = 2 * WIDTH;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] edge_det;

    logic [EM_W-1:0]  edge_mode_q, edge_mode_d;
    logic [WIDTH-1:0] irq_mask_q,  irq_mask_d;
    logic [WIDTH-1:0] capture_q,   capture_d;
    logic [3:0]       cnt_sel_q,   cnt_sel_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             ovf_q,       ovf_d;
    logic [31:0]      rdata_d;

    logic             wr_en;
    logic             cnt_clr;
    logic             cnt_hit;
    logic [WIDTH-1:0] clr_mask;
    logic             unused_wdata;

    assign sync_w       = sync_q[SYNC_STAGES-1];
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign unused_wdata = &{1'b0, bus.writedata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_w;
        end
    end

    always_comb begin
        edge_det = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (edge_mode_q[2*i +: 2])
                2'b00:   edge_det[i] = ~prev_q[i] &  sync_w[i];
                2'b01:   edge_det[i] =  prev_q[i] & ~sync_w[i];
                2'b10:   edge_det[i] =  prev_q[i] ^  sync_w[i];
                default: edge_det[i] = 1'b0;
            endcase
        end
    end

    // Out-of-range channel selects never match, so they count nothing.
    always_comb begin
        cnt_hit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_sel_q == 4'(i)) cnt_hit = edge_det[i];
        end
    end

    always_comb begin
        edge_mode_d = edge_mode_q;
        irq_mask_d  = irq_mask_q;
        cnt_sel_d   = cnt_sel_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        clr_mask    = '0;
        cnt_clr     = wr_en && (bus.address == 3'd4 || bus.address == 3'd5);

        if (wr_en && bus.address == 3'd1) edge_mode_d = bus.writedata[EM_W-1:0];
        if (wr_en && bus.address == 3'd2) irq_mask_d  = bus.writedata[WIDTH-1:0];
        if (wr_en && bus.address == 3'd3) clr_mask    = bus.writedata[WIDTH-1:0];
        if (wr_en && bus.address == 3'd4) cnt_sel_d   = bus.writedata[3:0];

        // A fresh edge beats a simultaneous write-1-to-clear.
        capture_d = (capture_q & ~clr_mask) | edge_det;

        if (cnt_clr) begin
            count_d = cnt_hit ? CNT_W'(1) : '0;
            ovf_d   = 1'b0;
        end else if (cnt_hit) begin
            count_d = count_q + CNT_W'(1);
            ovf_d   = ovf_q | (&count_q);
        end
    end

    always_comb begin
        rdata_d = '0;
        unique case (bus.address)
            3'd0: rdata_d[WIDTH-1:0] = sync_w;
            3'd1: rdata_d[EM_W-1:0]  = edge_mode_q;
            3'd2: rdata_d[WIDTH-1:0] = irq_mask_q;
            3'd3: rdata_d[WIDTH-1:0] = capture_q;
            3'd4: rdata_d[3:0]       = cnt_sel_q;
            3'd5: begin
                rdata_d[CNT_W-1:0] = count_q;
                rdata_d[31]        = ovf_q;
            end
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_mode_q   <= '0;
            irq_mask_q    <= IRQ_MASK_RST;
            capture_q     <= '0;
            cnt_sel_q     <= '0;
            count_q       <= '0;
            ovf_q         <= 1'b0;
            bus.readdata  <= '0;
        end else begin
            edge_mode_q   <= edge_mode_d;
            irq_mask_q    <= irq_mask_d;
            capture_q     <= capture_d;
            cnt_sel_q     <= cnt_sel_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
            bus.readdata  <= rdata_d;
        end
    end

    assign irq = |(capture_q & irq_mask_q);

endmodule

// File: tb/tb_freq_edge_pio.sv
// Scoreboard bench for freq_edge_pio: directed stimulus queues expected
// readdata/irq values per cycle, a negedge monitor pops and compares them.
module tb_freq_edge_pio;

    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        int          due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_port = '0;
    logic       irq;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [31:0] mon_got;

    freq_edge_pio_if bus_if ();

    freq_edge_pio #(
        .WIDTH(8), .SYNC_STAGES(2), .CNT_W(4), .IRQ_MASK_RST(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_if), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int kind, input string name,
                                 input logic [31:0] exp, input int due);
        exp_t e;
        int   i;
        e.name = name; e.kind = kind; e.exp = exp; e.due = due;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].due > due) i--;
        exp_q.insert(i, e);
    endfunction

    // Monitor: compare every expectation that falls due in this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e   = exp_q.pop_front();
            mon_got = (mon_e.kind == K_IRQ) ? {31'b0, irq} : bus_if.readdata;
            tests++;
            if (mon_e.due < cyc) begin
                fails++;
                $display("FAIL %s: check missed its cycle (due %0d, now %0d)",
                         mon_e.name, mon_e.due, cyc);
            end else if (mon_got !== mon_e.exp) begin
                fails++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h",
                         mon_e.name, mon_got, mon_e.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        @(posedge clk); #1;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        push(K_RD, name, exp, cyc + 1);
        @(posedge clk); #1;
        bus_if.chipselect = 1'b0;
    endtask

    task automatic chk_irq(input logic exp, input string name);
        push(K_IRQ, name, {31'b0, exp}, cyc);
    endtask

    task automatic toggle(input logic [7:0] pat, input int n);
        for (int k = 0; k < n; k++) begin
            in_port = pat;  tick(3);
            in_port = 8'h00; tick(3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;

        // Reset state
        @(posedge clk); #1;
        push(K_RD, "rst_readdata", 32'h0, cyc);
        chk_irq(1'b0, "rst_irq");
        @(posedge clk); #1;
        reset = 1'b0;
        tick(3);

        // Rising edge on ch0 with exact capture/irq latency, then W1C clears irq
        wr(3'd2, 32'h01);
        rd(3'd2, 32'h01, "mask_rw");
        rd(3'd1, 32'h00, "mode_reset_val");
        in_port = 8'h01;
        push(K_IRQ, "irq_before_latency", 32'h0, cyc + 2);
        push(K_IRQ, "irq_at_latency", 32'h1, cyc + 3);
        tick(4);
        rd(3'd3, 32'h01, "cap_ch0_rise");
        chk_irq(1'b1, "irq_held");
        wr(3'd3, 32'h01);
        chk_irq(1'b0, "irq_cleared");
        rd(3'd3, 32'h00, "cap_cleared");

        // Mixed modes: ch0 falling, ch1 any edge
        in_port = 8'h00; tick(4);
        wr(3'd1, 32'h0009);
        rd(3'd1, 32'h0009, "mode_rw");
        in_port = 8'h03; tick(4);
        rd(3'd3, 32'h02, "cap_mixed_rise");
        wr(3'd3, 32'h02);
        rd(3'd3, 32'h00, "cap_mixed_clr");
        in_port = 8'h00; tick(4);
        rd(3'd3, 32'h03, "cap_mixed_fall");
        wr(3'd3, 32'h03);
        rd(3'd3, 32'h00, "cap_mixed_clr2");
        in_port = 8'h02; tick(1);
        wr(3'd3, 32'h02);
        rd(3'd3, 32'h02, "edge_wins_clear");
        in_port = 8'h00; tick(4);
        wr(3'd3, 32'hFF);
        rd(3'd3, 32'h00, "cap_clr_all");

        // Counter on ch3 with 4-bit wrap and sticky overflow
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h3);
        rd(3'd4, 32'h3, "cnt_sel_rw");
        toggle(8'h08, 15);
        tick(2);
        rd(3'd5, 32'h0000000F, "count_15");
        toggle(8'h08, 2);
        tick(2);
        rd(3'd5, 32'h80000001, "count_wrap_ovf");
        wr(3'd5, 32'h0);
        rd(3'd5, 32'h0, "count_clr");
        wr(3'd3, 32'hFF);

        // Out-of-range channel select and reserved addresses
        wr(3'd4, 32'h9);
        rd(3'd4, 32'h9, "cnt_sel_9");
        toggle(8'hFF, 2);
        rd(3'd5, 32'h0, "count_sel_oob");
        rd(3'd6, 32'h0, "addr6_zero");
        wr(3'd6, 32'hFFFFFFFF);
        rd(3'd6, 32'h0, "addr6_after_wr");
        rd(3'd7, 32'h0, "addr7_zero");
        wr(3'd3, 32'hFF);

        // Count clear coinciding with a counted edge leaves count 1
        wr(3'd4, 32'h0);
        in_port = 8'h01; tick(1);
        wr(3'd5, 32'h0);
        rd(3'd5, 32'h1, "clr_with_edge");
        in_port = 8'h00; tick(3);

        // Data register
        in_port = 8'hA5; tick(4);
        rd(3'd0, 32'h000000A5, "data_a5");
        in_port = 8'h00; tick(4);

        // Asynchronous reset mid-count
        wr(3'd2, 32'hFF);
        wr(3'd4, 32'h0);
        wr(3'd3, 32'hFF);
        toggle(8'hFF, 5);
        rd(3'd5, 32'h5, "count_5");
        rd(3'd3, 32'hFF, "cap_ff");
        chk_irq(1'b1, "irq_before_rst");
        wr(3'd1, 32'hFFFF);
        rd(3'd5, 32'h5, "count_5_again");
        @(posedge clk); #3;
        reset = 1'b1;
        push(K_RD, "async_rst_readdata", 32'h0, cyc);
        chk_irq(1'b0, "async_rst_irq");
        tick(2);
        reset = 1'b0;
        rd(3'd1, 32'h0, "mode_after_rst");
        rd(3'd2, 32'h0, "mask_after_rst");
        rd(3'd3, 32'h0, "cap_after_rst");
        rd(3'd4, 32'h0, "sel_after_rst");
        rd(3'd5, 32'h0, "count_after_rst");
        chk_irq(1'b0, "irq_after_rst");

        tick(4);
        if (exp_q.size() > 0) begin
            fails++;
            tests++;
            $display("FAIL drain: got %0d pending checks, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
